// File: rtl/frame_config_loader.sv
// -----------------------------------------------------------------------------
// frame_config_loader
//
// Configuration sequencer for the eFPGA fabric. Takes a 32-bit bitstream word
// stream over a valid/ready handshake, locks onto SYNC_WORD, parses per-frame
// headers, assembles one full-height frame of configuration data and pulses a
// single FrameStrobe bit so every tile in the addressed column latches it.
//
// Ports
//   CLK            configuration clock, rising edge
//   reset          synchronous, active-high reset
//   in_data        bitstream word
//   in_valid       in_data is valid
//   in_ready       loader accepts a word this cycle (registered, state-only)
//   FrameData      assembled frame, row word k on bits [k*32 +: 32]
//   FrameStrobe    one-hot strobe, bit = col*MAX_FRAMES_PER_COL + frame
//   config_done    one-cycle pulse after an end command is accepted
//   cfg_error      sticky error flag, cleared only by reset
//   frames_written saturating count of strobed frames
// -----------------------------------------------------------------------------
module frame_config_loader #(
    parameter int unsigned NUM_ROWS           = 4,
    parameter int unsigned NUM_COLUMNS        = 4,
    parameter int unsigned MAX_FRAMES_PER_COL = 20,
    parameter logic [31:0] SYNC_WORD          = 32'hFAB0_FAB1
) (
    input  logic                                      CLK,
    input  logic                                      reset,
    input  logic [31:0]                               in_data,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    output logic [NUM_ROWS*32-1:0]                    FrameData,
    output logic [NUM_COLUMNS*MAX_FRAMES_PER_COL-1:0] FrameStrobe,
    output logic                                      config_done,
    output logic                                      cfg_error,
    output logic [15:0]                               frames_written
);

    localparam int unsigned DATA_W   = NUM_ROWS * 32;
    localparam int unsigned STROBE_W = NUM_COLUMNS * MAX_FRAMES_PER_COL;
    localparam int unsigned CNT_W    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int unsigned COL_W    = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1;
    localparam int unsigned FRAME_W  = (MAX_FRAMES_PER_COL > 1) ? $clog2(MAX_FRAMES_PER_COL) : 1;

    localparam logic [7:0] CMD_FRAME = 8'h01;
    localparam logic [7:0] CMD_END   = 8'hFF;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_HEADER  = 3'd1,
        ST_DATA    = 3'd2,
        ST_STROBE  = 3'd3,
        ST_DISCARD = 3'd4
    } state_e;

    state_e                state_q,      state_d;
    logic [CNT_W-1:0]      cnt_q,        cnt_d;
    logic [COL_W-1:0]      col_q,        col_d;
    logic [FRAME_W-1:0]    frame_q,      frame_d;
    logic [DATA_W-1:0]     frame_data_q, frame_data_d;
    logic [STROBE_W-1:0]   strobe_q,     strobe_d;
    logic                  ready_q,      ready_d;
    logic                  done_q,       done_d;
    logic                  error_q,      error_d;
    logic [15:0]           fw_q,         fw_d;

    // Header field decode and handshake qualifiers
    logic                  xfer;
    logic [7:0]            hdr_cmd;
    logic [7:0]            hdr_col;
    logic [4:0]            hdr_frame;
    logic                  hdr_addr_ok;
    logic                  last_word;
    logic [31:0]           strobe_idx;
    logic [STROBE_W-1:0]   strobe_onehot;

    assign xfer        = in_valid && ready_q;
    assign hdr_cmd     = in_data[31:24];
    assign hdr_col     = in_data[15:8];
    assign hdr_frame   = in_data[4:0];
    assign hdr_addr_ok = (32'(hdr_col) < NUM_COLUMNS) && (32'(hdr_frame) < MAX_FRAMES_PER_COL);
    assign last_word   = (cnt_q == CNT_W'(NUM_ROWS - 1));

    // One-hot strobe for the latched column/frame address
    assign strobe_idx = 32'(col_q) * MAX_FRAMES_PER_COL + 32'(frame_q);

    always_comb begin
        strobe_onehot = '0;
        for (int i = 0; i < STROBE_W; i++) begin
            strobe_onehot[i] = (strobe_idx == 32'(i));
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        col_d        = col_q;
        frame_d      = frame_q;
        frame_data_d = frame_data_q;
        strobe_d     = '0;
        done_d       = 1'b0;
        error_d      = error_q;
        fw_d         = fw_q;

        case (state_q)
            ST_HUNT: begin
                if (xfer && (in_data == SYNC_WORD)) begin
                    state_d = ST_HEADER;
                end
            end

            ST_HEADER: begin
                if (xfer) begin
                    if (hdr_cmd == CMD_FRAME) begin
                        cnt_d = '0;
                        if (hdr_addr_ok) begin
                            col_d   = COL_W'(hdr_col);
                            frame_d = FRAME_W'(hdr_frame);
                            state_d = ST_DATA;
                        end else begin
                            // Bad address still carries a payload; swallow it
                            error_d = 1'b1;
                            state_d = ST_DISCARD;
                        end
                    end else if (hdr_cmd == CMD_END) begin
                        done_d  = 1'b1;
                        state_d = ST_HUNT;
                    end else begin
                        // Unknown command: stream alignment is lost, resync
                        error_d = 1'b1;
                        state_d = ST_HUNT;
                    end
                end
            end

            ST_DATA: begin
                if (xfer) begin
                    for (int k = 0; k < NUM_ROWS; k++) begin
                        if (cnt_q == CNT_W'(k)) begin
                            frame_data_d[k*32 +: 32] = in_data;
                        end
                    end
                    if (last_word) begin
                        cnt_d    = '0;
                        strobe_d = strobe_onehot;
                        fw_d     = (fw_q == 16'hFFFF) ? fw_q : fw_q + 16'd1;
                        state_d  = ST_STROBE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_STROBE: begin
                state_d = ST_HEADER;
            end

            ST_DISCARD: begin
                if (xfer) begin
                    if (last_word) begin
                        cnt_d   = '0;
                        state_d = ST_HEADER;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_HUNT;
            end
        endcase

        // Ready is derived from the upcoming state only, never from in_valid
        ready_d = (state_d != ST_STROBE);
    end

    // State and output registers
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q      <= ST_HUNT;
            cnt_q        <= '0;
            col_q        <= '0;
            frame_q      <= '0;
            frame_data_q <= '0;
            strobe_q     <= '0;
            ready_q      <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            fw_q         <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            col_q        <= col_d;
            frame_q      <= frame_d;
            frame_data_q <= frame_data_d;
            strobe_q     <= strobe_d;
            ready_q      <= ready_d;
            done_q       <= done_d;
            error_q      <= error_d;
            fw_q         <= fw_d;
        end
    end

    assign in_ready       = ready_q;
    assign FrameData      = frame_data_q;
    assign FrameStrobe    = strobe_q;
    assign config_done    = done_q;
    assign cfg_error      = error_q;
    assign frames_written = fw_q;

endmodule

// File: tb/tb_frame_config_loader.sv
// -----------------------------------------------------------------------------
// Bench for frame_config_loader. A word-level reference model tracks what the
// loader should present after each clock edge; strobe events go into a
// scoreboard queue that an independent monitor drains when FrameStrobe rises.
// -----------------------------------------------------------------------------
module tb_frame_config_loader;

    localparam int unsigned NR   = 4;
    localparam int unsigned NC   = 4;
    localparam int unsigned MF   = 20;
    localparam int unsigned FD_W = NR * 32;
    localparam int unsigned ST_W = NC * MF;
    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

    logic              CLK = 1'b0;
    logic              reset = 1'b1;
    logic [31:0]       in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [FD_W-1:0]   FrameData;
    logic [ST_W-1:0]   FrameStrobe;
    logic              config_done;
    logic              cfg_error;
    logic [15:0]       frames_written;

    frame_config_loader #(
        .NUM_ROWS(NR), .NUM_COLUMNS(NC), .MAX_FRAMES_PER_COL(MF), .SYNC_WORD(SYNC)
    ) dut (
        .CLK(CLK), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .FrameData(FrameData), .FrameStrobe(FrameStrobe),
        .config_done(config_done), .cfg_error(cfg_error), .frames_written(frames_written)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int              idx;
        logic [FD_W-1:0] fd;
        int              fw;
        int              cyc;
    } strobe_t;

    strobe_t         sq[$];
    bit              m_synced, m_drop, m_ready, m_done, m_err;
    int              m_left, m_idx, m_fw;
    logic [FD_W-1:0] m_fd;
    int              n_pushed = 0;

    task automatic model_reset();
        m_synced = 0; m_drop = 0; m_ready = 1; m_done = 0; m_err = 0;
        m_left = 0; m_idx = 0; m_fw = 0; m_fd = '0;
        sq.delete();
    endtask

    // Apply the effect of one clock edge: v/w are what is presented before it
    task automatic model_edge(input bit v, input logic [31:0] w);
        bit acc;
        acc     = v && m_ready;
        m_ready = 1;
        m_done  = 0;
        if (acc) begin
            if (!m_synced) begin
                if (w == SYNC) begin
                    m_synced = 1;
                    m_left   = 0;
                end
            end else if (m_left > 0) begin
                if (!m_drop) m_fd[(NR - m_left)*32 +: 32] = w;
                m_left--;
                if (m_left == 0 && !m_drop) begin
                    if (m_fw < 65535) m_fw++;
                    sq.push_back('{m_idx, m_fd, m_fw, cyc + 1});
                    n_pushed++;
                    m_ready = 0;
                end
            end else begin
                case (w[31:24])
                    8'h01: begin
                        m_left = NR;
                        m_drop = !((w[15:8] < NC) && (w[4:0] < MF));
                        if (m_drop) m_err = 1;
                        else        m_idx = int'(w[15:8]) * MF + int'(w[4:0]);
                    end
                    8'hFF: begin
                        m_done   = 1;
                        m_synced = 0;
                    end
                    default: begin
                        m_err    = 1;
                        m_synced = 0;
                    end
                endcase
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input bit v, input logic [31:0] w, output bit acc);
        @(negedge CLK);
        in_valid = v;
        in_data  = w;
        acc      = v && m_ready;
        model_edge(v, w);
    endtask

    task automatic send(input logic [31:0] w);
        bit acc;
        int tries;
        tries = 0;
        do begin
            cycle(1'b1, w, acc);
            tries++;
        end while (!acc && tries < 4);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, $urandom, acc);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        reset    = 1'b1;
        in_valid = 1'b0;
        model_reset();
        @(negedge CLK);
        reset = 1'b0;
    endtask

    task automatic send_frame(input int col, input int fr);
        send({8'h01, 8'($urandom), 8'(col), 3'($urandom), 5'(fr)});
        for (int i = 0; i < NR; i++) send($urandom);
    endtask

    // ---------------- monitor ----------------
    bit  mon_en = 0;
    bit  prev_nz = 0;
    int  n_seen = 0, n_done = 0, n_notready = 0, last_bit = -1;
    int  st_bits[$];
    int  st_cycs[$];

    initial begin
        strobe_t         e;
        logic [ST_W-1:0] exp_vec;
        forever begin
            @(posedge CLK);
            #2;
            if (mon_en) begin
                chk("in_ready", in_ready, m_ready);
                chk("cfg_error", cfg_error, m_err);
                chk("config_done", config_done, m_done);
                chk("frames_written", frames_written, m_fw);
                chk("FrameData", FrameData, m_fd);
                if (config_done) n_done++;
                if (!in_ready) n_notready++;
                if (FrameStrobe != '0) begin
                    chk("strobe_adjacent", prev_nz, 1'b0);
                    for (int i = 0; i < ST_W; i++) if (FrameStrobe[i]) last_bit = i;
                    st_bits.push_back(last_bit);
                    st_cycs.push_back(cyc);
                    if (sq.size() == 0) begin
                        chk("unexpected_strobe", FrameStrobe, '0);
                    end else begin
                        e = sq.pop_front();
                        n_seen++;
                        exp_vec = '0;
                        exp_vec[e.idx] = 1'b1;
                        chk("FrameStrobe", FrameStrobe, exp_vec);
                        chk("strobe_cycle", cyc, e.cyc);
                        chk("strobe_FrameData", FrameData, e.fd);
                        chk("strobe_frames_written", frames_written, e.fw);
                    end
                end
                if (sq.size() > 0 && sq[0].cyc < cyc) begin
                    chk("missed_strobe_cycle", cyc, sq[0].cyc);
                    void'(sq.pop_front());
                end
                prev_nz = (FrameStrobe != '0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int              s0, d0, nr0, op;
        logic [FD_W-1:0] fd0;
        model_reset();
        repeat (2) @(negedge CLK);
        mon_en = 1;
        reset  = 1'b0;
        @(posedge CLK);
        #2;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_FrameData", FrameData, '0);
        chk("rst_FrameStrobe", FrameStrobe, '0);
        chk("rst_config_done", config_done, 1'b0);
        chk("rst_cfg_error", cfg_error, 1'b0);
        chk("rst_frames_written", frames_written, 16'd0);

        // Basic frame
        send(SYNC);
        send(32'h0100_0203);
        send(32'h1111_1111); send(32'h2222_2222); send(32'h3333_3333); send(32'h4444_4444);
        idle(3);
        chk("basic_strobes", n_seen, 1);
        chk("basic_strobe_bit", last_bit, 43);
        chk("basic_frames_written", frames_written, 16'd1);
        chk("basic_FrameData", FrameData, {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111});

        // Hunt filtering
        do_reset();
        s0 = n_seen;
        send(32'hDEAD_BEEF); send(32'h0100_0000); send(32'h0100_0203);
        for (int i = 0; i < NR; i++) send($urandom);
        idle(2);
        chk("hunt_no_strobe", n_seen, s0);
        chk("hunt_no_error", cfg_error, 1'b0);
        send(SYNC);
        send_frame(1, 5);
        idle(2);
        chk("hunt_one_strobe", n_seen, s0 + 1);

        // Out-of-range address
        fd0 = FrameData; s0 = n_seen; d0 = n_done;
        send(32'h0100_0415);
        for (int i = 0; i < NR; i++) send($urandom);
        send(32'hFF00_0000);
        idle(3);
        chk("oor_cfg_error", cfg_error, 1'b1);
        chk("oor_FrameData_kept", FrameData, fd0);
        chk("oor_no_strobe", n_seen, s0);
        chk("oor_done_once", n_done, d0 + 1);

        // Back-to-back frames, in_valid held high
        do_reset();
        s0 = n_seen; nr0 = n_notready;
        send(SYNC);
        send_frame(0, 0);
        send_frame(3, 19);
        idle(3);
        chk("b2b_strobes", n_seen, s0 + 2);
        if (st_bits.size() >= 2) begin
            chk("b2b_bit0", st_bits[st_bits.size()-2], 0);
            chk("b2b_bit79", st_bits[st_bits.size()-1], 79);
            chk("b2b_spacing", st_cycs[st_cycs.size()-1] - st_cycs[st_cycs.size()-2], 6);
        end
        chk("b2b_notready_cycles", n_notready - nr0, 2);

        // Stall between data words 1 and 2
        s0 = n_seen;
        send(32'h0100_0101);
        send(32'hA0A0_0000); send(32'hA1A1_1111);
        idle(7);
        send(32'hA2A2_2222); send(32'hA3A3_3333);
        idle(2);
        chk("stall_strobe", n_seen, s0 + 1);
        chk("stall_FrameData", FrameData, {32'hA3A3_3333, 32'hA2A2_2222, 32'hA1A1_1111, 32'hA0A0_0000});

        // Reset after data word 2, then a header without sync is ignored
        send(32'h0100_0102);
        send($urandom); send($urandom); send($urandom);
        do_reset();
        #3;
        chk("midrst_FrameData", FrameData, '0);
        chk("midrst_frames_written", frames_written, 16'd0);
        chk("midrst_in_ready", in_ready, 1'b1);
        s0 = n_seen;
        send_frame(0, 1);
        idle(3);
        chk("midrst_hunt_ignores", n_seen, s0);

        // Reset during the strobe cycle
        send(SYNC);
        send_frame(2, 7);
        do_reset();
        idle(3);
        chk("strobe_rst_single", n_seen, s0 + 1);
        chk("strobe_rst_cleared", FrameStrobe, '0);

        // Bad command
        s0 = n_seen;
        send(SYNC);
        send(32'h7700_0000);
        idle(1);
        chk("badcmd_cfg_error", cfg_error, 1'b1);
        for (int i = 0; i < NR; i++) send($urandom);
        send_frame(1, 1);
        idle(2);
        chk("badcmd_no_strobe", n_seen, s0);
        send(SYNC);
        send_frame(1, 1);
        idle(2);
        chk("badcmd_resync_strobe", n_seen, s0 + 1);

        // Randomized traffic
        do_reset();
        for (int t = 0; t < 300; t++) begin
            op = $urandom_range(0, 9);
            case (op)
                0, 1:    send(SYNC);
                2, 3, 4, 5: send_frame($urandom_range(0, NC - 1), $urandom_range(0, MF - 1));
                6: begin
                    if ($urandom_range(0, 1) == 1) send_frame(NC + $urandom_range(0, 200), $urandom_range(0, 31));
                    else                           send_frame($urandom_range(0, NC - 1), MF + $urandom_range(0, 31 - MF));
                end
                7:       send(32'hFF00_0000 | (32'($urandom) & 32'h00FF_FFFF));
                8:       send($urandom);
                default: send({8'($urandom_range(2, 254)), 24'($urandom)});
            endcase
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            if ($urandom_range(0, 40) == 0) do_reset();
        end
        idle(4);

        chk("queue_empty", sq.size(), 0);
        chk("strobe_total", n_seen, n_pushed);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
